// File: rtl/multicycle_sequencer.sv
`timescale 1ns / 1ps
// multicycle_sequencer
//   Multi-cycle control FSM for the 18-bit-instruction CPU datapath.
//   Fetch/Decode/Execute/Mem/Writeback sequencing over a single shared memory
//   port with a ready handshake. Owns the ZF/CF flag register (updated by CMP)
//   and resolves conditional branches in DECODE.
//
// Ports
//   clk, reset            : clock (rising edge), asynchronous active-low reset
//   opcode                : IR[17:14], valid from DECODE onward
//   alu_zero, alu_carry   : ALU status, sampled into zf_q/cf_q at the end of CMP EXEC
//   mem_ready             : memory completes the current request this cycle
//   ir_write, pc_write    : IR load / PC update strobes
//   pc_src                : 0 = PC+1, 1 = branch/jump target
//   mem_req, mem_we       : memory request valid / write request
//   mem_addr_src          : 0 = PC, 1 = ALU result
//   alu_src, alu_op       : ALU operand B select / operation
//   reg_write, mem_to_reg : register file write enable / writeback source
//   zf_q, cf_q            : registered flags
//   fault                 : memory timeout, sticky until reset
//   state_o               : current state encoding
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TW             = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_src,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       zf_q,
  output logic       cf_q,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpAddi = 4'b0010;
  localparam logic [3:0] OpAnd  = 4'b0011;
  localparam logic [3:0] OpAndi = 4'b0100;
  localparam logic [3:0] OpNand = 4'b0101;
  localparam logic [3:0] OpNor  = 4'b0110;
  localparam logic [3:0] OpJump = 4'b0111;
  localparam logic [3:0] OpLd   = 4'b1000;
  localparam logic [3:0] OpSt   = 4'b1001;
  localparam logic [3:0] OpCmp  = 4'b1010;
  localparam logic [3:0] OpJe   = 4'b1011;
  localparam logic [3:0] OpJa   = 4'b1100;
  localparam logic [3:0] OpJb   = 4'b1101;
  localparam logic [3:0] OpJae  = 4'b1110;
  localparam logic [3:0] OpJbe  = 4'b1111;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluAnd  = 3'b001;
  localparam logic [2:0] AluNand = 3'b010;
  localparam logic [2:0] AluNor  = 3'b011;
  localparam logic [2:0] AluSub  = 3'b100;

  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StFault  = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          zf_d, cf_d, fault_q, fault_d;

  // {alu_op, alu_src} for the instruction held in IR.
  function automatic logic [3:0] alu_ctrl(input logic [3:0] op);
    logic [3:0] r;
    r = {AluAdd, 1'b0};
    case (op)
      OpAdd:        r = {AluAdd, 1'b0};
      OpAddi:       r = {AluAdd, 1'b1};
      OpAnd:        r = {AluAnd, 1'b0};
      OpAndi:       r = {AluAnd, 1'b1};
      OpNand:       r = {AluNand, 1'b0};
      OpNor:        r = {AluNor, 1'b0};
      OpLd, OpSt:   r = {AluAdd, 1'b1};
      OpCmp:        r = {AluSub, 1'b0};
      default:      r = {AluAdd, 1'b0};
    endcase
    return r;
  endfunction

  // Branch conditions look at the registered flags only.
  function automatic logic branch_taken(input logic [3:0] op, input logic zf, input logic cf);
    logic t;
    t = 1'b0;
    case (op)
      OpJe:    t = zf;
      OpJa:    t = !zf && !cf;
      OpJb:    t = cf;
      OpJae:   t = !cf;
      OpJbe:   t = cf || zf;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic is_alu_op;
  assign is_alu_op = (opcode == OpAdd) || (opcode == OpAddi) || (opcode == OpAnd) ||
                     (opcode == OpAndi) || (opcode == OpNand) || (opcode == OpNor);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      wait_q  <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    zf_d    = zf_q;
    cf_d    = cf_q;
    case (state_q)
      StFetch: begin
        // mem_ready on the timeout cycle still completes normally.
        if (mem_ready) begin
          state_d = StDecode;
        end else if (wait_q == TimeoutVal) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      StDecode: begin
        if (is_alu_op || opcode == OpLd || opcode == OpSt || opcode == OpCmp) begin
          state_d = StExec;
        end else begin
          state_d = StFetch;
        end
      end
      StExec: begin
        if (opcode == OpCmp) begin
          zf_d    = alu_zero;
          cf_d    = alu_carry;
          state_d = StFetch;
        end else if (opcode == OpLd || opcode == OpSt) begin
          state_d = StMem;
        end else if (is_alu_op) begin
          state_d = StWb;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (opcode == OpLd) ? StWb : StFetch;
        end else if (wait_q == TimeoutVal) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      StWb:    state_d = StFetch;
      StFault: state_d = StFault;
      default: state_d = StFetch;
    endcase
    fault_d = fault_q || (state_d == StFault);
  end

  // Output decode
  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    alu_src      = 1'b0;
    alu_op       = AluAdd;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      StDecode: begin
        if (opcode == OpJump || branch_taken(opcode, zf_q, cf_q)) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
      end
      StExec: begin
        {alu_op, alu_src} = alu_ctrl(opcode);
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = (opcode == OpSt);
        alu_op       = AluAdd;
        alu_src      = 1'b1;
      end
      StWb: begin
        reg_write         = 1'b1;
        mem_to_reg        = (opcode == OpLd);
        {alu_op, alu_src} = alu_ctrl(opcode);
      end
      default: ;
    endcase
    // While reset is held every strobe is forced low, so an in-flight
    // request (e.g. a store in MEM) is dropped immediately.
    if (!reset) begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_src = 1'b0;
      alu_src      = 1'b0;
      alu_op       = AluAdd;
      reg_write    = 1'b0;
      mem_to_reg   = 1'b0;
    end
  end

  assign fault   = fault_q;
  assign state_o = state_q;

  // Unused encoding kept for readability of the opcode map.
  logic unused_nop;
  assign unused_nop = (opcode == OpNop);

endmodule

// File: tb/tb_multicycle_sequencer.sv
`timescale 1ns / 1ps
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       alu_zero = 1'b0, alu_carry = 1'b0, mem_ready = 1'b0;
  logic       ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_src, alu_src;
  logic [2:0] alu_op;
  logic       reg_write, mem_to_reg, zf_q, cf_q, fault;
  logic [2:0] state_o;

  multicycle_sequencer #(
    .TIMEOUT_CYCLES(4),
    .TW(3)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_src(mem_addr_src), .alu_src(alu_src),
    .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .zf_q(zf_q),
    .cf_q(cf_q), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // {state, ir_w, pc_w, pc_src, req, we, addr_src, alu_src, alu_op, reg_w, m2r, zf, cf, fault}
  logic [17:0] dut_vec;
  assign dut_vec = {state_o, ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_src,
                    alu_src, alu_op, reg_write, mem_to_reg, zf_q, cf_q, fault};

  logic [17:0] exp_q[$];
  string       name_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        tzf = 1'b0, tcf = 1'b0;

  // Monitor: one expected vector per cycle, compared away from the clock edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [17:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if (dut_vec !== e) begin
        fails++;
        $display("FAIL %s: got %05h required %05h", n, dut_vec, e);
      end
    end
  end

  function automatic logic [17:0] mk(logic [2:0] st, logic irw, logic pcw, logic pcs,
                                     logic req, logic we, logic asrc, logic alsrc,
                                     logic [2:0] aop, logic rw, logic m2r, logic z,
                                     logic c, logic f);
    return {st, irw, pcw, pcs, req, we, asrc, alsrc, aop, rw, m2r, z, c, f};
  endfunction

  function automatic logic [17:0] e_fetch(logic rdy);
    return mk(3'd0, rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, tzf, tcf, 1'b0);
  endfunction
  function automatic logic [17:0] e_decode(logic t);
    return mk(3'd1, 1'b0, t, t, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, tzf, tcf, 1'b0);
  endfunction
  function automatic logic [17:0] e_exec(logic [2:0] aop, logic src);
    return mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, src, aop, 1'b0, 1'b0, tzf, tcf, 1'b0);
  endfunction
  function automatic logic [17:0] e_mem(logic we);
    return mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, we, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, tzf, tcf, 1'b0);
  endfunction
  function automatic logic [17:0] e_wb(logic [2:0] aop, logic src, logic m2r);
    return mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, src, aop, 1'b1, m2r, tzf, tcf, 1'b0);
  endfunction
  function automatic logic [17:0] e_fault();
    return mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, tzf, tcf, 1'b1);
  endfunction

  // One cycle of stimulus plus the response expected during that cycle.
  task automatic step(input string nm, input logic rst, input logic [3:0] op, input logic rdy,
                      input logic z, input logic c, input logic [17:0] e);
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    alu_zero  = z;
    alu_carry = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic alu_instr(input string nm, input logic [3:0] op, input logic [2:0] aop,
                           input logic src);
    step({nm, "_fetch"}, 1'b1, op, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step({nm, "_decode"}, 1'b1, op, 1'b1, 1'b0, 1'b0, e_decode(1'b0));
    step({nm, "_exec"}, 1'b1, op, 1'b1, 1'b0, 1'b0, e_exec(aop, src));
    step({nm, "_wb"}, 1'b1, op, 1'b1, 1'b0, 1'b0, e_wb(aop, src, 1'b0));
  endtask

  task automatic branch(input string nm, input logic [3:0] op, input logic taken);
    step({nm, "_fetch"}, 1'b1, op, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step({nm, "_decode"}, 1'b1, op, 1'b0, 1'b0, 1'b0, e_decode(taken));
  endtask

  task automatic cmp(input logic z, input logic c);
    step("cmp_fetch", 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step("cmp_decode", 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("cmp_exec", 1'b1, 4'b1010, 1'b0, z, c, e_exec(3'b100, 1'b0));
    tzf = z;
    tcf = c;
  endtask

  initial begin
    // Reset held, then released: outputs follow FETCH.
    step("reset_hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 18'd0);

    alu_instr("add", 4'b0001, 3'b000, 1'b0);
    alu_instr("andi", 4'b0100, 3'b001, 1'b1);
    alu_instr("nand", 4'b0101, 3'b010, 1'b0);
    alu_instr("nor", 4'b0110, 3'b011, 1'b0);

    // LD with three wait cycles in MEM: 8 cycles total.
    step("ld_fetch", 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step("ld_decode", 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("ld_exec", 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, e_exec(3'b000, 1'b1));
    for (int i = 0; i < 3; i++) begin
      step("ld_mem_wait", 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, e_mem(1'b0));
    end
    step("ld_mem_done", 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, e_mem(1'b0));
    step("ld_wb", 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, e_wb(3'b000, 1'b1, 1'b1));

    // ST, zero-wait.
    step("st_fetch", 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step("st_decode", 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, e_decode(1'b0));
    step("st_exec", 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, e_exec(3'b000, 1'b1));
    step("st_mem", 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, e_mem(1'b1));

    // CMP equal, then JE sees the new flags.
    cmp(1'b1, 1'b0);
    branch("je", 4'b1011, 1'b1);

    // CMP below: JA no, JB yes, JBE yes, JAE no.
    cmp(1'b0, 1'b1);
    branch("ja", 4'b1100, 1'b0);
    branch("jb", 4'b1101, 1'b1);
    branch("jbe", 4'b1111, 1'b1);
    branch("jae", 4'b1110, 1'b0);
    branch("jump", 4'b0111, 1'b1);
    branch("nop", 4'b0000, 1'b0);

    // mem_ready on the final allowed wait cycle completes normally.
    for (int i = 0; i < 4; i++) begin
      step("fetch_wait", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    end
    step("fetch_last_ready", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step("nop2_decode", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));

    // Reset during an ST in MEM abandons the write.
    step("str_fetch", 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step("str_decode", 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("str_exec", 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, e_exec(3'b000, 1'b1));
    step("str_mem", 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, e_mem(1'b1));
    tzf = 1'b0;
    tcf = 1'b0;
    step("str_reset", 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 18'd0);
    step("str_after_fetch", 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    step("str_after_fetch_rdy", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step("str_after_nop", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("st2_fetch", 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step("st2_decode", 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("st2_exec", 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, e_exec(3'b000, 1'b1));
    step("st2_mem", 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, e_mem(1'b1));

    // Timeout: five idle FETCH cycles, then FAULT until reset.
    for (int i = 0; i < 5; i++) begin
      step("to_fetch", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      step("to_fault", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, e_fault());
    end
    step("to_reset", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 18'd0);
    step("to_resume_fetch", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    step("to_resume_decode", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 18-bit-instruction CPU datapath. Replaces single-cycle decode with a Fetch/Decode/Execute/Mem/Writeback sequence.
- Sequences the shared instruction/data memory port with a ready handshake and owns the architectural ZF/CF flag register updated by CMP.
- Resolves conditional branches.
- Sits between the instruction register, ALU, register file, PC and the single memory port.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for mem_ready before entering FAULT. Range 1..255.
- TW, 8: width of the wait counter. Must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  4  IR[17:14]. Valid from DECODE onward.
- alu_zero  in  1  ALU result == 0.
- alu_carry  in  1  ALU carry/borrow out.
- mem_ready  in  1  memory completes the current request this cycle.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+1, 1 = branch/jump target.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write request (ST).
- mem_addr_src  out  1  0 = PC, 1 = ALU result.
- alu_src  out  1  0 = register, 1 = immediate.
- alu_op  out  3  000 ADD, 001 AND, 010 NAND, 011 NOR, 100 SUB.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source is memory data.
- zf_q  out  1  registered zero flag.
- cf_q  out  1  registered carry flag.
- fault  out  1  memory timeout; sticky until reset.
- state_o  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to FETCH.
  - zf_q, cf_q, fault and the wait counter clear to 0.
  - All registered controls are 0. Outputs follow the FETCH decode once reset is released.
- Opcodes:
  - ADD 0001, ADDI 0010, AND 0011, ANDI 0100, NAND 0101, NOR 0110.
  - JUMP 0111, LD 1000, ST 1001, CMP 1010.
  - JE 1011, JA 1100, JB 1101, JAE 1110, JBE 1111.
  - 0000 is a NOP.
- FETCH:
  - Drives mem_req=1, mem_addr_src=0, mem_we=0.
  - In the cycle mem_ready=1, ir_write=1, pc_write=1 and pc_src=0 (Mealy on mem_ready); next state is DECODE.
- DECODE (1 cycle):
  - JUMP: pc_write=1, pc_src=1.
  - Conditional branch taken: pc_write=1, pc_src=1. Conditions use registered flags:
    - JE: zf_q.
    - JA: !zf_q & !cf_q.
    - JB: cf_q.
    - JAE: !cf_q.
    - JBE: cf_q | zf_q.
  - Branch not taken, or NOP: no strobes.
  - Next state: FETCH for all jumps, branches and NOP; EXEC otherwise.
- EXEC (1 cycle):
  - alu_op and alu_src by opcode: ADD/AND/NAND/NOR use alu_src=0; ADDI/ANDI use alu_src=1; LD/ST use ADD with alu_src=1; CMP uses SUB with alu_src=0.
  - CMP: zf_q<=alu_zero and cf_q<=alu_carry at the end of EXEC; next state FETCH.
  - LD/ST: next state MEM.
  - ALU ops: next state WB.
- MEM:
  - mem_req=1, mem_addr_src=1, mem_we=1 for ST. alu_op=ADD and alu_src=1 are held.
  - On mem_ready: LD goes to WB, ST goes to FETCH.
- WB (1 cycle):
  - reg_write=1.
  - LD: mem_to_reg=1.
  - ALU ops: EXEC's alu_op/alu_src are held and mem_to_reg=0.
  - Next state FETCH.
- Wait counter:
  - Increments each FETCH/MEM cycle with mem_ready=0 and clears on leaving those states.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0, next state is FAULT.
  - mem_ready=1 on that same cycle wins: normal completion.
- FAULT:
  - fault=1 and all strobes 0.
  - Held until reset.
- Flags change only on CMP. A branch immediately after CMP sees the updated flags.
- mem_req stays high and the address is stable until mem_ready.
- No strobe (ir_write, pc_write, reg_write, mem_we) is asserted for more than one cycle per instruction phase.
- Latency with zero-wait memory:
  - ALU op: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - CMP: 3 cycles.
  - Jump/branch: 2 cycles.
- Reset mid-MEM write: the request is abandoned. No mem_we after reset is released.

Test Plan:
- ADD, mem_ready tied high → FETCH,DECODE,EXEC,WB. reg_write high exactly 1 cycle in WB. alu_op=000, alu_src=0.
- LD, mem_ready delayed 3 cycles in MEM → mem_req=1, mem_addr_src=1 held 4 cycles. WB with mem_to_reg=1, reg_write=1. Total 8 cycles.
- CMP with alu_zero=1, alu_carry=0, then JE → zf_q=1. DECODE of JE drives pc_write=1, pc_src=1.
- CMP with alu_zero=0, alu_carry=1, then JA → JA not taken: no pc_write in DECODE. JB taken; JBE taken; JAE not taken.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → FAULT after 5 cycles: fault=1, all strobes 0. Stays in FAULT until reset=0, then resumes in FETCH.
- ST with reset asserted during MEM → state 0, outputs cleared asynchronously. mem_we not reasserted until the next ST reaches MEM.
